// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register file with synchronised inputs, write commit and MISO read-back.
// Optional SPI_BURST_EN: multi-word frames with address auto-increment.
module spi_regfile_peripheral #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       m_clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       mosi,
  input  logic                       cs_n,
  output logic                       miso,
  output logic                       miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE, S_ADDR, S_DATA, S_DONE
  } state_t;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t                   state;
  logic [CNT_W-1:0]         bit_cnt;
  logic [ADDR_W-1:0]        hdr;
  logic [ADDR_W-1:0]        addr_q;
  logic [DATA_W-1:0]        wdat;
  logic [DATA_W-1:0]        dsr;
  logic                     rw;
  logic                     ovl;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
`ifdef SPI_BURST_EN
  logic                     any_word;
`endif

  logic [ADDR_W:0]   hdr_nx;
  logic [DATA_W-1:0] wdat_nx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] wa;
  logic              last_addr;
  logic              last_data;
  logic              do_wr;
  logic              err;

  function automatic logic [DATA_W-1:0] rd_reg(
    input logic [NUM_REGS*DATA_W-1:0] r,
    input logic [ADDR_W-1:0]          a
  );
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) v = r[i*DATA_W +: DATA_W];
    return v;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NR;
  endfunction

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;
  assign hdr_nx    = {hdr, mosi_s2};
  assign wdat_nx   = {wdat[DATA_W-2:0], mosi_s2};
  assign regs_flat = regs_q;

  always_comb begin
    last_addr = (state == S_ADDR) && (bit_cnt == CNT_W'(ADDR_W));
    last_data = (state == S_DATA) && (bit_cnt == CNT_W'(DATA_W - 1));
    do_wr = 1'b0;
    err   = 1'b0;
    wa    = addr_q;
    wd    = wdat;
`ifdef SPI_BURST_EN
    rd_word = rd_reg(regs_q,
      last_addr ? hdr_nx[ADDR_W-1:0] : addr_q + ADDR_W'(1));
    // Whole words are already committed; only a partial tail is an error.
    if (cs_rise) begin
      err = (state != S_IDLE) &&
            !(state == S_DATA && bit_cnt == '0 && any_word);
    end else if (!cs_fall && sclk_rise && last_data && rw) begin
      do_wr = in_range(addr_q);
      err   = !in_range(addr_q);
      wd    = wdat_nx;
    end
`else
    rd_word = rd_reg(regs_q, hdr_nx[ADDR_W-1:0]);
    if (cs_rise && state != S_IDLE) begin
      do_wr = state == S_DONE && rw && !ovl && in_range(addr_q);
      err   = state != S_DONE || ovl || (rw && !in_range(addr_q));
    end
`endif
  end

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      hdr       <= '0;
      addr_q    <= '0;
      wdat      <= '0;
      dsr       <= '0;
      rw        <= 1'b0;
      ovl       <= 1'b0;
      regs_q    <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
`ifdef SPI_BURST_EN
      any_word  <= 1'b0;
`endif
    end else begin
      wr_pulse  <= do_wr;
      frame_err <= err;
      if (do_wr) begin
        wr_addr <= wa;
        for (int i = 0; i < NUM_REGS; i++)
          if (wa == ADDR_W'(i)) regs_q[i*DATA_W +: DATA_W] <= wd;
      end
      if (cs_rise) begin
        state   <= S_IDLE;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else if (cs_fall) begin
        state   <= S_ADDR;
        bit_cnt <= '0;
        hdr     <= '0;
        wdat    <= '0;
        dsr     <= '0;
        ovl     <= 1'b0;
        miso    <= 1'b0;
        miso_oe <= 1'b1;
`ifdef SPI_BURST_EN
        any_word <= 1'b0;
`endif
      end else if (sclk_rise) begin
        unique case (state)
          S_ADDR: begin
            hdr     <= hdr_nx[ADDR_W-1:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_addr) begin
              state   <= S_DATA;
              bit_cnt <= '0;
              rw      <= hdr_nx[ADDR_W];
              addr_q  <= hdr_nx[ADDR_W-1:0];
              dsr     <= rd_word;
              miso    <= ~hdr_nx[ADDR_W] & rd_word[DATA_W-1];
            end
          end
          S_DATA: begin
            wdat    <= wdat_nx;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_data) begin
`ifdef SPI_BURST_EN
              bit_cnt  <= '0;
              addr_q   <= addr_q + ADDR_W'(1);
              any_word <= 1'b1;
              dsr      <= rd_word;
              miso     <= ~rw & rd_word[DATA_W-1];
`else
              state <= S_DONE;
`endif
            end
          end
          S_DONE: ovl <= 1'b1;
          default: ;
        endcase
      end else if (sclk_fall && state == S_DATA && !rw && bit_cnt != '0) begin
        // The MSB is already on MISO before the first data rise; skip that fall.
        dsr  <= dsr << 1;
        miso <= dsr[DATA_W-2];
      end
    end
  end

endmodule

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
- Parametrised SPI (mode 0) register-file peripheral, successor to the fixed 5x8-bit write-only block.
- Generalised register count, data width and address width; adds read-back on MISO, write strobe and framing-error reporting.
- Accepts raw SCLK/MOSI/CS_N and synchronises them internally into the m_clk domain.
- Sits between the chip pads and the control registers consumed by the PWM/config logic.

Parameters:
- NUM_REGS, 8, number of registers; addresses 0..NUM_REGS-1 are valid (1..2^ADDR_W).
- DATA_W, 8, register and data-phase width in bits (>=2).
- ADDR_W, 7, address field width.
- Derived, not overridable: FRAME_W = 1 + ADDR_W + DATA_W.

Ports:
- m_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  raw SPI clock, idle low.
- mosi  in  1  raw SPI data in.
- cs_n  in  1  raw chip select, active low.
- miso  out  1  SPI data out, registered.
- miso_oe  out  1  MISO output enable; the pad tristate lives at top level.
- regs_flat  out  NUM_REGS*DATA_W  register contents; reg i at [i*DATA_W +: DATA_W].
- wr_pulse  out  1  one-cycle strobe on every committed write.
- wr_addr  out  ADDR_W  address of the last committed write.
- frame_err  out  1  one-cycle strobe when a frame is discarded.

Behaviour:
- Reset (async, rst_n low): all registers 0; miso=0, miso_oe=0, wr_pulse=0, wr_addr=0, frame_err=0; counters and shift registers cleared; synchronisers reset to idle (sclk=0, mosi=0, cs_n=1).
- Reset asserted mid-frame aborts the frame. No commit occurs. After release, nothing happens until the next CS falling edge.
- Synchronisation:
  - 2-FF synchroniser on each of sclk, mosi and cs_n.
  - Edges are detected against a third registered copy.
  - Inputs are valid only for f_sclk <= f_m_clk/8.
- Frame format, MSB first, sampled on SCLK rising edge:
  - bit 0: R/W_n (1=write, 0=read).
  - next ADDR_W bits: address.
  - next DATA_W bits: data.
- CS falling edge: bit counter=0, shift register=0, state IDLE->ADDR, miso_oe=1.
- State machine IDLE / ADDR / DATA / DONE:
  - ADDR counts 1+ADDR_W rising edges, then goes to DATA.
  - DATA counts DATA_W rising edges, then goes to DONE.
  - DONE ignores further SCLK edges, but each extra edge sets an overlength flag.
- Write commit (without burst):
  - Commits only at CS rising edge, only if the state is DONE, R/W_n=1, no overlength, and addr<NUM_REGS.
  - Target register updates on the cycle after the CS rise is detected; wr_pulse=1 and wr_addr=addr in that same cycle.
- Read:
  - On the m_clk cycle that detects the last address rising edge, the data shifter loads reg[addr] (0 if addr>=NUM_REGS).
  - miso takes its MSB in that same cycle.
  - On each subsequent detected SCLK falling edge in DATA, shift left and drive the next bit.
  - miso holds its last bit through DONE.
  - Reads never modify registers.
- Outside read data phase: miso=0 (ADDR phase and write frames).
- CS rising edge, any state: return to IDLE, miso_oe=0, miso=0.
- frame_err pulses for one cycle on CS rise if:
  - state is not DONE (short frame), or
  - overlength, or
  - write with addr>=NUM_REGS.
- A CS rise in IDLE (no preceding fall) produces no frame_err.
- Simultaneous CS rise and SCLK edge detected in the same cycle: CS takes priority and the SCLK edge is ignored.
- Register read-during-write: a read frame returns the value before any commit that happens in the same cycle.

Optional Feature:
Macro SPI_BURST_EN.
- Defined:
  - After the first data word, DATA wraps back to bit 0 instead of entering DONE (no overlength in write frames).
  - Each completed data word commits immediately, on the cycle after its last rising edge is detected. The address used is base+word_index, modulo 2^ADDR_W.
  - Words whose address >= NUM_REGS are dropped and pulse frame_err.
  - Reads auto-increment the same way: the next word is loaded at the final rising edge of the current word.
  - A CS rise with a partial trailing word discards only that word and pulses frame_err.
  - A CS rise after only whole words is clean.
- Undefined: single-word frames exactly as described in Behaviour; the burst logic is absent from the netlist.

Test Plan:
- Reset, then write frame 1_0000011_0xA5 (DATA_W=8) -> after CS rise: reg3=0xA5, wr_pulse one cycle, wr_addr=3; all other regs 0.
- Write 0x3C to reg5, then read frame 0_0000101 followed by 8 clocks -> MISO bits sampled on rising edges = 0x3C; miso_oe high only while CS low.
- 15-bit write frame and 17-bit write frame to reg0 -> reg0 unchanged, frame_err pulses once per frame.
- Write to addr 9 (NUM_REGS=8) -> no register change, frame_err=1; read of addr 9 returns 0x00.
- Assert rst_n low after 10 bits of a write to reg1 holding 0x77 -> reg1=0 after reset; a following complete write of 0x12 to reg1 lands correctly.
- SPI_BURST_EN defined: write base 6 with data 0x11,0x22,0x33 plus 4 extra bits -> reg6=0x11, reg7=0x22, addr 8 dropped with frame_err; trailing partial word raises frame_err; exactly 2 wr_pulses.
